// File: rtl/cmp_pkg.sv
// Shared constants and FSM state type for the sequential magnitude comparator.
package cmp_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

endpackage

// File: rtl/mag_cmp4.sv
// Combinational 4-bit magnitude comparator, 7485 core without cascade.
module mag_cmp4
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               lt,
    output logic               gt,
    output logic               eq
);

    // Unsigned slice relation; exactly one output is high.
    always_comb begin
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
    end

endmodule

// File: rtl/seq_mag_compare.sv
// Sequential MSB-first magnitude comparator: one 4-bit slice per clock,
// early exit on the first unequal slice, 7485-style cascade on full equality.
module seq_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             cas_lt,
    input  logic             cas_gt,
    input  logic             cas_eq,
    output logic             busy,
    output logic             done,
    output logic             alb,
    output logic             agb,
    output logic             aeb,
    output logic [6:0]       slices_used
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order, so the slice comparator itself never needs a signed path.
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               cas_lt_q;
    logic               cas_gt_q;
    logic               cas_eq_q;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic               sl_lt;
    logic               sl_gt;
    logic               sl_eq;
    logic [6:0]         used_k;
    logic [WIDTH-1:0]   flip;

    assign flip   = signed_mode ? MSB_MASK : '0;
    assign a_sl   = a_q[idx*SLICE_W +: SLICE_W];
    assign b_sl   = b_q[idx*SLICE_W +: SLICE_W];
    assign used_k = 7'(NSLICE) - 7'(idx);
    assign busy   = (state == COMPARE);

    mag_cmp4 u_cmp (
        .a  (a_sl),
        .b  (b_sl),
        .lt (sl_lt),
        .gt (sl_gt),
        .eq (sl_eq)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: leave COMPARE on a mismatch or after the last slice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COMPARE;
            COMPARE: if (!sl_eq || idx == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, slice walk and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            cas_lt_q    <= 1'b0;
            cas_gt_q    <= 1'b0;
            cas_eq_q    <= 1'b0;
            idx         <= '0;
            done        <= 1'b0;
            alb         <= 1'b0;
            agb         <= 1'b0;
            aeb         <= 1'b0;
            slices_used <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q         <= a ^ flip;
                        b_q         <= b ^ flip;
                        cas_lt_q    <= cas_lt;
                        cas_gt_q    <= cas_gt;
                        cas_eq_q    <= cas_eq;
                        idx         <= IDX_W'(NSLICE - 1);
                        alb         <= 1'b0;
                        agb         <= 1'b0;
                        aeb         <= 1'b0;
                        slices_used <= '0;
                    end
                end
                COMPARE: begin
                    if (!sl_eq) begin
                        alb         <= sl_lt;
                        agb         <= sl_gt;
                        aeb         <= 1'b0;
                        slices_used <= used_k;
                        done        <= 1'b1;
                    end else if (idx == '0) begin
                        // Cascade priority eq > gt > lt; nothing asserted means equal.
                        aeb         <= cas_eq_q | ~(cas_gt_q | cas_lt_q);
                        agb         <= ~cas_eq_q & cas_gt_q;
                        alb         <= ~cas_eq_q & ~cas_gt_q & cas_lt_q;
                        slices_used <= used_k;
                        done        <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed self-checking bench with an expected-result scoreboard queue.
module tb_seq_mag_compare;

    typedef struct {
        logic [2:0] flags;   // {alb, agb, aeb}
        int         k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_mode = 1'b0;
    logic        cas_lt = 1'b0;
    logic        cas_gt = 1'b0;
    logic        cas_eq = 1'b0;
    logic        busy, done, alb, agb, aeb;
    logic [6:0]  slices_used;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4, done4, alb4, agb4, aeb4;
    logic [6:0]  slices4;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_mag_compare #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .cas_lt(cas_lt), .cas_gt(cas_gt), .cas_eq(cas_eq),
        .busy(busy), .done(done), .alb(alb), .agb(agb), .aeb(aeb),
        .slices_used(slices_used)
    );

    seq_mag_compare #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .signed_mode(1'b0), .cas_lt(1'b0), .cas_gt(1'b0), .cas_eq(1'b0),
        .busy(busy4), .done(done4), .alb(alb4), .agb(agb4), .aeb(aeb4),
        .slices_used(slices4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: whole-word compare plus position of the highest differing nibble.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic sm, input logic lt, input logic gt,
                                   input logic eq);
        exp_t e;
        logic [15:0] d;
        d = x ^ y;
        e.k = 4;
        for (int i = 0; i < 16; i++) if (d[i]) e.k = 4 - i / 4;
        if (d == '0) begin
            if (eq)      e.flags = 3'b001;
            else if (gt) e.flags = 3'b010;
            else if (lt) e.flags = 3'b100;
            else         e.flags = 3'b001;
        end else if (sm) begin
            e.flags = ($signed(x) < $signed(y)) ? 3'b100 : 3'b010;
        end else begin
            e.flags = (x < y) ? 3'b100 : 3'b010;
        end
        return e;
    endfunction

    // Called at a negedge: drive a request, let one edge accept it, check clears.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic sm,
                            input logic lt, input logic gt, input logic eq);
        a = x; b = y; signed_mode = sm; cas_lt = lt; cas_gt = gt; cas_eq = eq;
        start = 1'b1;
        exp_q.push_back(model(x, y, sm, lt, gt, eq));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        chk("accept_flags_clr", {alb, agb, aeb}, 0);
        chk("accept_used_clr", slices_used, 0);
    endtask

    // Wait (bounded) for done, then compare against the scoreboard head.
    task automatic wait_result(input string tag, input int pre);
        int   cyc;
        exp_t e;
        cyc = pre;
        while (!done && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_done"}, done, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_latency"}, cyc, e.k);
            chk({tag, "_flags"}, {alb, agb, aeb}, e.flags);
            chk({tag, "_used"}, slices_used, e.k);
        end
    endtask

    // After done: one more idle cycle must keep the result and drop done.
    task automatic check_hold(input string tag);
        logic [2:0] f;
        logic [6:0] u;
        f = {alb, agb, aeb};
        u = slices_used;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_done"}, done, 0);
        chk({tag, "_hold_busy"}, busy, 0);
        chk({tag, "_hold_flags"}, {alb, agb, aeb}, f);
        chk({tag, "_hold_used"}, slices_used, u);
    endtask

    initial begin
        int cyc;
        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {alb, agb, aeb}, 0);
        chk("rst_used", slices_used, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // MSB mismatch unsigned and signed
        start_op(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_result("msb_uns", 0);
        chk("msb_uns_agb", agb, 1);
        check_hold("msb_uns");
        start_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_result("msb_sgn", 0);
        chk("msb_sgn_alb", alb, 1);

        // LSB mismatch
        start_op(16'h003F, 16'h003D, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_result("lsb", 0);
        chk("lsb_agb", agb, 1);

        // Equal operands through the cascade inputs
        start_op(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_result("eq_caseq", 0);
        chk("eq_caseq_aeb", aeb, 1);
        start_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_result("eq_caslt", 0);
        chk("eq_caslt_alb", alb, 1);
        start_op(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_result("eq_casnone", 0);
        start_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_result("eq_casgtlt", 0);
        check_hold("eq_casgtlt");

        // Signed mid-slice cases
        start_op(16'hFFF0, 16'hFFF1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_result("sgn_neg", 0);
        start_op(16'h0120, 16'hF120, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_result("sgn_pos_neg", 0);

        // Start held high with other operands while busy must be ignored
        start_op(16'h003F, 16'h003D, 1'b0, 1'b0, 1'b0, 1'b0);
        a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abuse_busy1", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("abuse_busy2", busy, 1);
        start = 1'b0;
        wait_result("abuse", 2);

        // Back-to-back: new start in the done cycle
        start_op(16'h4000, 16'h5000, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_result("b2b_first", 0);
        start_op(16'h0007, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_result("b2b_second", 0);

        // Reset in the middle of a compare (slice index 2)
        a = 16'hFFFF; b = 16'hFFFF; signed_mode = 1'b0;
        cas_lt = 1'b0; cas_gt = 1'b0; cas_eq = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_flags", {alb, agb, aeb}, 0);
        chk("midrst_used", slices_used, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cyc++;
        end
        chk("midrst_no_done", cyc, 0);
        start_op(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_result("after_rst", 0);

        // WIDTH=4 instance
        a4 = 4'h8; b4 = 4'h6; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        chk("w4_busy", busy4, 1);
        @(posedge clk);
        @(negedge clk);
        chk("w4_done", done4, 1);
        chk("w4_flags", {alb4, agb4, aeb4}, 3'b010);
        chk("w4_used", slices4, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
